// File: rtl/position_cursor_decoder_pkg.sv
// Shared board types and helpers for the position cursor decoder and display path.
// Sizes supported: up to 64 cells (onehot_of works on a 64-bit canvas).
package position_pkg;

  typedef enum logic {PLAY = 1'b0, FULL = 1'b1} board_state_t;

  localparam int DEFAULT_NUM_POS = 9;

  // One-hot of a cell index on a 64-bit canvas; callers truncate to their board size.
  function automatic logic [63:0] onehot_of(input logic [5:0] idx);
    return 64'd1 << idx;
  endfunction

endpackage

// File: rtl/position_cursor_decoder_free_cell_scan.sv
// Next-free-cell finder: single-cycle priority scan over the NUM_POS-1 cells
// after (FORWARD=1) or before (FORWARD=0) the cursor, wrapping around the board.
module free_cell_scan #(
  parameter int NUM_POS = 9,
  parameter int POS_W   = $clog2(NUM_POS),
  parameter bit FORWARD = 1'b1
) (
  input  logic [NUM_POS-1:0] occupied,
  input  logic [POS_W-1:0]   cursor,
  output logic               found,
  output logic [POS_W-1:0]   idx
);

  int cur_s;
  int cand_s;

  // Scan from the farthest candidate inward so the nearest free cell wins.
  always_comb begin
    found  = 1'b0;
    idx    = cursor;
    cur_s  = int'(cursor);
    cand_s = 0;
    for (int k = NUM_POS - 1; k >= 1; k--) begin
      if (FORWARD) begin
        cand_s = (cur_s + k >= NUM_POS) ? (cur_s + k - NUM_POS) : (cur_s + k);
      end else begin
        cand_s = (cur_s - k < 0) ? (cur_s - k + NUM_POS) : (cur_s - k);
      end
      if (!occupied[cand_s]) begin
        found = 1'b1;
        idx   = POS_W'(cand_s);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/position_cursor_decoder.sv
// Registered board cursor with occupancy tracking and gated one-hot cell enable.
// Build option: POSITION_CURSOR_SKIP_OCCUPIED_EN makes stepping skip occupied cells.
module position_cursor_decoder
  import position_pkg::*;
#(
  parameter int NUM_POS = DEFAULT_NUM_POS,
  parameter int POS_W   = $clog2(NUM_POS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               load,
  input  logic [POS_W-1:0]   pos_in,
  input  logic               step_next,
  input  logic               step_prev,
  input  logic               commit,
  input  logic               clear_board,
  output logic [NUM_POS-1:0] out_en,
  output logic [POS_W-1:0]   cursor,
  output logic [NUM_POS-1:0] occupied,
  output logic               commit_ok,
  output logic               commit_err,
  output logic               full
);

  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(NUM_POS - 1);
  localparam logic [POS_W:0]   NUM_POS_V = (POS_W + 1)'(NUM_POS);

  board_state_t       state_r, state_s;
  logic [POS_W-1:0]   cursor_r, cursor_s;
  logic [NUM_POS-1:0] occupied_r, occupied_s;
  logic               commit_ok_r, commit_ok_s;
  logic               commit_err_r, commit_err_s;
  logic [POS_W-1:0]   next_idx_s, prev_idx_s;
  logic [NUM_POS-1:0] onehot_s;

`ifdef POSITION_CURSOR_SKIP_OCCUPIED_EN
  logic             next_found_s, prev_found_s;
  logic [POS_W-1:0] next_scan_s, prev_scan_s;

  free_cell_scan #(.NUM_POS(NUM_POS), .POS_W(POS_W), .FORWARD(1'b1)) u_scan_next (
    .occupied (occupied_r),
    .cursor   (cursor_r),
    .found    (next_found_s),
    .idx      (next_scan_s)
  );

  free_cell_scan #(.NUM_POS(NUM_POS), .POS_W(POS_W), .FORWARD(1'b0)) u_scan_prev (
    .occupied (occupied_r),
    .cursor   (cursor_r),
    .found    (prev_found_s),
    .idx      (prev_scan_s)
  );

  assign next_idx_s = next_found_s ? next_scan_s : cursor_r;
  assign prev_idx_s = prev_found_s ? prev_scan_s : cursor_r;
`else
  assign next_idx_s = (cursor_r == LAST_POS) ? {POS_W{1'b0}} : cursor_r + POS_W'(1);
  assign prev_idx_s = (cursor_r == {POS_W{1'b0}}) ? LAST_POS : cursor_r - POS_W'(1);
`endif

  // Board state and datapath register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= PLAY;
      cursor_r     <= {POS_W{1'b0}};
      occupied_r   <= {NUM_POS{1'b0}};
      commit_ok_r  <= 1'b0;
      commit_err_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cursor_r     <= cursor_s;
      occupied_r   <= occupied_s;
      commit_ok_r  <= commit_ok_s;
      commit_err_r <= commit_err_s;
    end
  end

  // One prioritised action per cycle; commit is judged on the registered cursor.
  always_comb begin
    state_s      = state_r;
    cursor_s     = cursor_r;
    occupied_s   = occupied_r;
    commit_ok_s  = 1'b0;
    commit_err_s = 1'b0;
    if (clear_board) begin
      occupied_s = {NUM_POS{1'b0}};
    end else if (load) begin
      cursor_s = ({1'b0, pos_in} < NUM_POS_V) ? pos_in : {POS_W{1'b0}};
    end else if (commit && enable) begin
      if (state_r == FULL || occupied_r[cursor_r]) begin
        commit_err_s = 1'b1;
      end else begin
        occupied_s[cursor_r] = 1'b1;
        commit_ok_s          = 1'b1;
      end
    end else if (step_next && !step_prev) begin
      cursor_s = next_idx_s;
    end else if (step_prev && !step_next) begin
      cursor_s = prev_idx_s;
    end else begin
      cursor_s = cursor_r;
    end

    case (state_r)
      PLAY: begin
        if (!clear_board && (&occupied_s)) begin
          state_s = FULL;
        end else begin
          state_s = PLAY;
        end
      end
      FULL: begin
        if (clear_board) begin
          state_s = PLAY;
        end else begin
          state_s = FULL;
        end
      end
      default: state_s = PLAY;
    endcase
  end

  assign onehot_s   = NUM_POS'(onehot_of(6'(cursor_r)));
  assign out_en     = enable ? onehot_s : {NUM_POS{1'b0}};
  assign cursor     = cursor_r;
  assign occupied   = occupied_r;
  assign commit_ok  = commit_ok_r;
  assign commit_err = commit_err_r;
  assign full       = (state_r == FULL);

endmodule

// File: tb/tb_position_cursor_decoder.sv
// Directed bench for position_cursor_decoder: commit pulses go through a
// scoreboard queue checked by a monitor; cursor/occupancy are checked inline.
module tb_position_cursor_decoder;

  localparam int NUM_POS = 9;
  localparam int POS_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable, load, step_next, step_prev, commit, clear_board;
  logic [POS_W-1:0]   pos_in;
  logic [NUM_POS-1:0] out_en, occupied;
  logic [POS_W-1:0]   cursor;
  logic               commit_ok, commit_err, full;

  int vectors     = 0;
  int miscompares = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  position_cursor_decoder #(.NUM_POS(NUM_POS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .pos_in(pos_in),
    .step_next(step_next), .step_prev(step_prev), .commit(commit),
    .clear_board(clear_board), .out_en(out_en), .cursor(cursor),
    .occupied(occupied), .commit_ok(commit_ok), .commit_err(commit_err), .full(full)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [POS_W-1:0] p);
    load = 1'b1; pos_in = p; tick(); load = 1'b0;
  endtask

  task automatic do_commit(input logic [1:0] exp);
    exp_q.push_back(exp);
    commit = 1'b1; tick(); commit = 1'b0;
  endtask

  task automatic do_next();
    step_next = 1'b1; tick(); step_next = 1'b0;
  endtask

  task automatic do_prev();
    step_prev = 1'b1; tick(); step_prev = 1'b0;
  endtask

  task automatic do_clear();
    clear_board = 1'b1; tick(); clear_board = 1'b0;
  endtask

  // Monitor: every commit pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && (commit_ok || commit_err)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pulse_unexpected: got ok=%0b err=%0b, expected no pulse", commit_ok, commit_err);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({commit_ok, commit_err} !== e) begin
          miscompares++;
          $display("FAIL pulse: got ok/err=%b, expected %b", {commit_ok, commit_err}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; pos_in = 4'd0; step_next = 1'b0;
    step_prev = 1'b0; commit = 1'b0; clear_board = 1'b0;
    tick(); tick();
    check("rst_cursor", 64'(cursor), 64'd0);
    check("rst_out_en", 64'(out_en), 64'd0);
    check("rst_occupied", 64'(occupied), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    rst = 1'b0;
    tick();

    enable = 1'b1; #1;
    check("en_out_en", 64'(out_en), 64'h001);
    enable = 1'b0; #1;
    check("dis_out_en", 64'(out_en), 64'h000);
    enable = 1'b1;

    for (int i = 1; i <= 9; i++) begin
      do_next();
      check("step_next_cursor", 64'(cursor), 64'(i % 9));
    end
    do_prev();
    check("prev_wrap_cursor", 64'(cursor), 64'd8);
    check("prev_wrap_out_en", 64'(out_en), 64'h100);

    do_load(4'd5);
    check("load5", 64'(cursor), 64'd5);
    do_load(4'd12);
    check("load12_oor", 64'(cursor), 64'd0);

    step_next = 1'b1; step_prev = 1'b1; tick(); step_next = 1'b0; step_prev = 1'b0;
    check("both_steps_hold", 64'(cursor), 64'd0);
    load = 1'b1; pos_in = 4'd3; step_next = 1'b1; tick(); load = 1'b0; step_next = 1'b0;
    check("load_over_step", 64'(cursor), 64'd3);

    do_load(4'd4);
    do_commit(2'b10);
    check("commit4_occ", 64'(occupied), 64'h010);
    do_commit(2'b01);
    check("recommit4_occ", 64'(occupied), 64'h010);
    enable = 1'b0;
    commit = 1'b1; tick(); commit = 1'b0;
    tick();
    check("dis_commit_occ", 64'(occupied), 64'h010);
    enable = 1'b1;

`ifdef POSITION_CURSOR_SKIP_OCCUPIED_EN
    do_clear();
    for (int i = 1; i <= 3; i++) begin
      do_load(4'(i));
      do_commit(2'b10);
    end
    check("skip_occ", 64'(occupied), 64'h00E);
    do_load(4'd0);
    do_next();
    check("skip_next", 64'(cursor), 64'd4);
    do_prev();
    check("skip_prev", 64'(cursor), 64'd0);
    do_clear();
    for (int i = 0; i < 8; i++) begin
      do_load(4'(i));
      do_commit(2'b10);
    end
    do_load(4'd8);
    do_next();
    check("skip_hold_next", 64'(cursor), 64'd8);
    do_prev();
    check("skip_hold_prev", 64'(cursor), 64'd8);
    do_clear();
    do_load(4'd4);
    do_commit(2'b10);
`else
    do_load(4'd3);
    do_next();
    check("plain_step_onto_occ", 64'(cursor), 64'd4);
`endif

    for (int i = 0; i < 9; i++) begin
      do_load(4'(i));
      check("full_before_last", 64'(full), 64'd0);
      do_commit((i == 4) ? 2'b01 : 2'b10);
    end
    check("all_occ", 64'(occupied), 64'h1FF);
    check("full_set", 64'(full), 64'd1);
    do_commit(2'b01);
    check("full_commit_occ", 64'(occupied), 64'h1FF);
    do_next();
    check("full_step", 64'(cursor), 64'd0);
    do_load(4'd7);
    check("full_load", 64'(cursor), 64'd7);
    clear_board = 1'b1; commit = 1'b1; tick(); clear_board = 1'b0; commit = 1'b0;
    check("clear_occ", 64'(occupied), 64'd0);
    check("clear_full", 64'(full), 64'd0);
    check("clear_cursor", 64'(cursor), 64'd7);

    do_load(4'd6);
    commit = 1'b1;
    @(posedge clk);
    #1 commit = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst_cursor", 64'(cursor), 64'd0);
    check("midrst_occ", 64'(occupied), 64'd0);
    check("midrst_pulse", 64'({commit_ok, commit_err}), 64'd0);
    check("midrst_out_en", 64'(out_en), 64'h001);
    check("midrst_full", 64'(full), 64'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/position_cursor_decoder.md
Name: position_cursor_decoder

Overview:
- Registered successor to the board position decoder: holds a cursor over NUM_POS board cells and drives a gated one-hot cell enable.
- Tracks which cells are occupied.
- Accepts load, step-next/step-prev and commit requests from the input/FSM layer.
- Sits between the player input logic and the per-cell display/marker registers.

Parameters:
- NUM_POS, 9, number of board cells (2..64).
- POS_W, $clog2(NUM_POS), cursor/index width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  gates out_en and qualifies commit.
- load  in  1  load cursor from pos_in.
- pos_in  in  POS_W  position to load.
- step_next  in  1  advance cursor by one (single-cycle pulse).
- step_prev  in  1  retreat cursor by one (single-cycle pulse).
- commit  in  1  claim cell at cursor (single-cycle pulse).
- clear_board  in  1  clear all occupancy.
- out_en  out  NUM_POS  one-hot of cursor when enable=1, else all zero.
- cursor  out  POS_W  current cursor index.
- occupied  out  NUM_POS  occupancy bitmap.
- commit_ok  out  1  one-cycle pulse: commit accepted.
- commit_err  out  1  one-cycle pulse: commit rejected.
- full  out  1  all cells occupied.

Behaviour:
- Reset (async, rst=1):
  - cursor=0, occupied=0, commit_ok=0, commit_err=0, state=PLAY.
  - full=0, out_en=0 whenever enable=0.
- out_en:
  - Combinational from the cursor register: out_en = enable ? (1<<cursor) : 0.
  - Cursor changes show on out_en the cycle after the request edge.
- Priority per clock edge: clear_board > load > commit > step_next > step_prev. Only one action is taken per cycle.
- Both step_next and step_prev high together: no movement.
- load:
  - pos_in < NUM_POS: cursor = pos_in.
  - pos_in >= NUM_POS: cursor = 0. This is the decided out-of-range rule.
- step_next: cursor = (cursor==NUM_POS-1) ? 0 : cursor+1.
- step_prev: cursor = (cursor==0) ? NUM_POS-1 : cursor-1.
- commit, evaluated on the registered cursor before any same-cycle update:
  - enable=0: ignored, no pulse.
  - enable=1 and cell free: set occupied[cursor]; commit_ok=1 next cycle.
  - enable=1 and cell occupied, or state=FULL: commit_err=1 next cycle; occupancy unchanged.
- commit_ok and commit_err are registered, mutually exclusive, and high for exactly one cycle.
- FSM, two states:
  - PLAY: default state.
  - PLAY -> FULL in the cycle occupied becomes all ones; full = (state==FULL).
  - FULL: cursor movement and load remain allowed; commits return commit_err.
  - FULL -> PLAY on clear_board.
- clear_board:
  - occupied=0 and state=PLAY on the next edge.
  - Cursor is preserved.
  - Any same-cycle commit is dropped with no pulse.
- Reset asserted mid-operation: everything returns to reset values immediately, without waiting for a clock edge. Pending pulses are lost.

Optional Feature:
- Macro: POSITION_CURSOR_SKIP_OCCUPIED_EN.
- Defined:
  - step_next/step_prev move to the nearest unoccupied cell in that direction, wrapping around the board.
  - The search is a single-cycle priority scan over NUM_POS-1 candidates, excluding the current cell.
  - No free cell other than the current one: cursor holds.
  - load is not affected by the skip rule.
- Undefined: plain ±1 wrap stepping as above; the scan logic is not synthesised.

Decomposition:
- Package position_pkg holds:
  - typedef enum logic {PLAY, FULL} board_state_t.
  - Constant DEFAULT_NUM_POS = 9.
  - Function onehot_of(idx), shared with the display path.
- Sub-module free_cell_scan: the direction-parameterised next-free-index finder used only under POSITION_CURSOR_SKIP_OCCUPIED_EN.

Test Plan:
- Reset then enable=1 -> cursor=0, out_en=9'b000000001; enable=0 -> out_en=0.
- step_next ×9 from 0 -> cursor returns to 0 after 8→0 wrap; step_prev from 0 -> cursor=8, out_en=9'b100000000.
- load pos_in=5 -> cursor=5; load pos_in=12 -> cursor=0.
- Commit at cursor=4 twice (enable=1) -> first commit_ok pulse and occupied=9'b000010000, second commit_err with occupancy unchanged; commit with enable=0 -> no pulse.
- Commit all 9 cells -> full=1, tenth commit -> commit_err; clear_board -> occupied=0, full=0, cursor unchanged. Assert rst mid-sequence -> outputs at reset values without a clock edge.
- SKIP_OCCUPIED_EN, occupied=9'b000001110, cursor=0, step_next -> cursor=4; step_prev from 4 -> cursor=0; 8 cells occupied, step at the free cell -> cursor holds.
